// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve unit.
// Entry layout and PC step used by the prediction queue and the redirect path.
package bru_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
        logic            backward;
    } pred_entry_t;

    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(PC_STEP);
    endfunction

endpackage

// File: rtl/bru_fifo.sv
// Circular buffer of in-flight predictions in program order.
// The count register decides full/empty; clear wins over push and pop.
module bru_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  pred_entry_t                i_din,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output pred_entry_t                o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    pred_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear && !rst) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions against EX outcomes, drives flush/redirect and predictor training.
// Optional saturating branch/mispredict counters are enabled with BRU_STATS_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid_i,
    input  logic [DATA_WIDTH-1:0]      pred_pc_i,
    input  logic [DATA_WIDTH-1:0]      pred_target_i,
    input  logic                       pred_taken_i,
    output logic                       pred_ready_o,
    input  logic                       resolve_valid_i,
    input  logic                       resolve_taken_i,
    output logic                       flush_o,
    output logic [DATA_WIDTH-1:0]      redirect_pc_o,
    output logic                       upd_valid_o,
    output logic [DATA_WIDTH-1:0]      upd_pc_o,
    output logic                       upd_taken_o,
    output logic                       upd_backward_o,
    output logic                       upd_correct_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic                       err_underflow_o
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]                stat_branches_o,
    output logic [31:0]                stat_mispredicts_o
`endif
);

    pred_entry_t     w_entry;
    pred_entry_t     w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_correct;
    logic            w_mispredict;
    logic [PC_W-1:0] w_redirect;

    logic            r_flush;
    logic [PC_W-1:0] r_redirect;
    logic            r_upd_valid;
    logic [PC_W-1:0] r_upd_pc;
    logic            r_upd_taken;
    logic            r_upd_backward;
    logic            r_upd_correct;
    logic            r_err;

    assign w_entry = '{pc:       pred_pc_i,
                       target:   pred_target_i,
                       taken:    pred_taken_i,
                       backward: (pred_target_i < pred_pc_i)};

    assign pred_ready_o = ~w_full;
    assign w_push       = pred_valid_i & ~w_full;
    assign w_pop        = resolve_valid_i & ~w_empty;
    assign w_correct    = (w_head.taken == resolve_taken_i);
    assign w_mispredict = w_pop & ~w_correct;
    assign w_redirect   = resolve_taken_i ? w_head.target : next_seq_pc(w_head.pc);

    // A mispredict flushes every younger entry, including one pushed this same cycle.
    bru_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_entry),
        .i_pop   (w_pop),
        .i_clear (w_mispredict),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush        <= 1'b0;
            r_redirect     <= '0;
            r_upd_valid    <= 1'b0;
            r_upd_pc       <= '0;
            r_upd_taken    <= 1'b0;
            r_upd_backward <= 1'b0;
            r_upd_correct  <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_flush     <= w_mispredict;
            r_upd_valid <= w_pop;
            if (w_pop) begin
                r_upd_pc       <= w_head.pc;
                r_upd_taken    <= resolve_taken_i;
                r_upd_backward <= w_head.backward;
                r_upd_correct  <= w_correct;
            end
            if (w_mispredict) r_redirect <= w_redirect;
            if (resolve_valid_i && w_empty) r_err <= 1'b1;
        end
    end

    assign flush_o         = r_flush;
    assign redirect_pc_o   = r_redirect;
    assign upd_valid_o     = r_upd_valid;
    assign upd_pc_o        = r_upd_pc;
    assign upd_taken_o     = r_upd_taken;
    assign upd_backward_o  = r_upd_backward;
    assign upd_correct_o   = r_upd_correct;
    assign err_underflow_o = r_err;

`ifdef BRU_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_pop)        r_stat_br  <= sat_inc(r_stat_br);
            if (w_mispredict) r_stat_mis <= sat_inc(r_stat_mis);
        end
    end

    assign stat_branches_o    = r_stat_br;
    assign stat_mispredicts_o = r_stat_mis;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases then random traffic vs a queue model.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_valid_i = 1'b0;
    logic [31:0] pred_pc_i = '0;
    logic [31:0] pred_target_i = '0;
    logic        pred_taken_i = 1'b0;
    logic        pred_ready_o;
    logic        resolve_valid_i = 1'b0;
    logic        resolve_taken_i = 1'b0;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic        upd_valid_o;
    logic [31:0] upd_pc_o;
    logic        upd_taken_o;
    logic        upd_backward_o;
    logic        upd_correct_o;
    logic [2:0]  occupancy_o;
    logic        err_underflow_o;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches_o;
    logic [31:0] stat_mispredicts_o;
`endif

    branch_resolve_unit #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_valid_i    (pred_valid_i),
        .pred_pc_i       (pred_pc_i),
        .pred_target_i   (pred_target_i),
        .pred_taken_i    (pred_taken_i),
        .pred_ready_o    (pred_ready_o),
        .resolve_valid_i (resolve_valid_i),
        .resolve_taken_i (resolve_taken_i),
        .flush_o         (flush_o),
        .redirect_pc_o   (redirect_pc_o),
        .upd_valid_o     (upd_valid_o),
        .upd_pc_o        (upd_pc_o),
        .upd_taken_o     (upd_taken_o),
        .upd_backward_o  (upd_backward_o),
        .upd_correct_o   (upd_correct_o),
        .occupancy_o     (occupancy_o),
        .err_underflow_o (err_underflow_o)
`ifdef BRU_STATS_EN
        ,
        .stat_branches_o    (stat_branches_o),
        .stat_mispredicts_o (stat_mispredicts_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        backward;
        logic        correct;
        logic        flush;
        logic [31:0] redir;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    logic        m_err = 1'b0;
    logic [31:0] m_redir = '0;
    int          passed = 0;
    int          total = 0;
    bit          checks_on = 1'b0;
    bit          mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle from a negedge; the model advances as the DUT will at the next posedge.
    task automatic step(input logic r, input logic pv, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pt, input logic rv, input logic rt);
        exp_t e;
        ent_t h;
        ent_t n;
        logic push;
        if (checks_on) begin
            check("occupancy", 32'(occupancy_o), 32'(mq.size()));
            check("pred_ready", 32'(pred_ready_o), 32'(mq.size() < DEPTH));
            check("err_underflow", 32'(err_underflow_o), 32'(m_err));
        end
        rst = r; pred_valid_i = pv; pred_pc_i = pc; pred_target_i = tgt;
        pred_taken_i = pt; resolve_valid_i = rv; resolve_taken_i = rt;
        n.pc = pc; n.tgt = tgt; n.taken = pt;
        push = pv && (mq.size() < DEPTH);
        if (r) begin
            mq.delete();
            m_err = 1'b0;
            m_redir = '0;
        end else if (rv && mq.size() > 0) begin
            h = mq.pop_front();
            e.pc = h.pc;
            e.taken = rt;
            e.backward = (h.tgt < h.pc);
            e.correct = (h.taken == rt);
            e.flush = !e.correct;
            if (!e.correct) begin
                m_redir = rt ? h.tgt : h.pc + 32'd4;
                mq.delete();
            end else if (push) begin
                mq.push_back(n);
            end
            e.redir = m_redir;
            sb.push_back(e);
        end else begin
            if (rv) m_err = 1'b1;
            if (push) mq.push_back(n);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (upd_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_upd_valid", 32'(upd_valid_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("upd_pc", upd_pc_o, e.pc);
                    check("upd_taken", 32'(upd_taken_o), 32'(e.taken));
                    check("upd_backward", 32'(upd_backward_o), 32'(e.backward));
                    check("upd_correct", 32'(upd_correct_o), 32'(e.correct));
                    check("flush", 32'(flush_o), 32'(e.flush));
                    check("redirect_pc", redirect_pc_o, e.redir);
                end
            end else begin
                check("flush_without_upd", 32'(flush_o), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        @(negedge clk);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks_on = 1'b1;
        mon_on = 1'b1;
        check("reset_flush", 32'(flush_o), 32'd0);
        check("reset_redirect", redirect_pc_o, 32'd0);
        check("reset_upd_valid", 32'(upd_valid_o), 32'd0);

        // Correct taken, forward branch
        step(1'b0, 1'b1, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("dir_correct", 32'({flush_o, upd_valid_o, upd_correct_o, upd_backward_o}), 32'b0110);

        // Mispredict, actual taken, backward branch
        step(1'b0, 1'b1, 32'h200, 32'h1F0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("dir_mis_taken", redirect_pc_o, 32'h1F0);

        // Mispredict, actual not taken
        step(1'b0, 1'b1, 32'h300, 32'h380, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("dir_mis_not_taken", redirect_pc_o, 32'h304);

        // Fall-through wraps past the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("dir_wrap", redirect_pc_o, 32'h0);

        // Fill, overflow push, drain in order
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 32'h1000 + 32'(i) * 32'h10, 32'h2000, 1'b0, 1'b0, 1'b0);
        check("dir_full_ready", 32'(pred_ready_o), 32'd0);
        check("dir_full_occ", 32'(occupancy_o), 32'd4);
        step(1'b0, 1'b1, 32'h9990, 32'h2000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            check("dir_order", upd_pc_o, 32'h1000 + 32'(i) * 32'h10);
        end

        // Mispredict with a concurrent push
        step(1'b0, 1'b1, 32'h400, 32'h480, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h410, 32'h490, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h420, 32'h4A0, 1'b1, 1'b1, 1'b0);
        check("dir_push_on_flush_occ", 32'(occupancy_o), 32'd0);
        check("dir_push_on_flush_flush", 32'(flush_o), 32'd1);

        // Underflow, then reset clears it
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("dir_underflow_err", 32'(err_underflow_o), 32'd1);
        check("dir_underflow_flush", 32'(flush_o), 32'd0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("dir_reset_err", 32'(err_underflow_o), 32'd0);
        check("dir_reset_occ", 32'(occupancy_o), 32'd0);

        // Reset with entries queued discards them without a flush
        step(1'b0, 1'b1, 32'h500, 32'h540, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h504, 32'h540, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("dir_midreset_flush", 32'(flush_o), 32'd0);

        for (int i = 0; i < 600; i++) begin
            a = $urandom() & 32'hFFFF_FFFC;
            b = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) b = a - 32'h20;
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), a, b,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)));
        end
        idle();
        idle();
        idle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
